// File: rtl/alu_vector_checker_if.sv
// Bus between the ALU vector checker and its host: vector load port, run control,
// ALU drive/return, and the result counters.
interface alu_vector_checker_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 5,
  parameter int unsigned ADDRW = 5
);
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_x;
  logic [WIDTH-1:0] wr_y;
  logic [WIDTH-1:0] wr_z;
  logic [OPW-1:0]   wr_op;
  logic [ADDRW:0]   num_tests;
  logic             start;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_z;
  logic             busy;
  logic             done;
  logic [ADDRW:0]   correct;
  logic [ADDRW:0]   failed;
  logic             fail_valid;
  logic [ADDRW-1:0] first_fail;

  modport master (
    output wr_en, wr_addr, wr_x, wr_y, wr_z, wr_op, num_tests, start, alu_z,
    input  alu_x, alu_y, alu_op, busy, done, correct, failed, fail_valid, first_fail
  );

  modport slave (
    input  wr_en, wr_addr, wr_x, wr_y, wr_z, wr_op, num_tests, start, alu_z,
    output alu_x, alu_y, alu_op, busy, done, correct, failed, fail_valid, first_fail
  );
endinterface

// File: rtl/alu_vector_checker.sv
// ALU vector engine: plays stored {x, y, op} vectors into the ALU, waits a fixed
// settle time, compares z against the stored expectation and counts outcomes.
module alu_vector_checker #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned OPW    = 5,
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned ADDRW  = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_vector_checker_if.slave  bus
);

  localparam int unsigned     CW       = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [ADDRW:0]  DEPTH_W  = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0]  ONE_N    = (ADDRW+1)'(1);
  localparam logic [ADDRW-1:0] ONE_I   = ADDRW'(1);
  localparam logic [CW-1:0]   SETTLE_W = CW'(SETTLE);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_mem_x [DEPTH];
  logic [WIDTH-1:0] r_mem_y [DEPTH];
  logic [WIDTH-1:0] r_mem_z [DEPTH];
  logic [OPW-1:0]   r_mem_op [DEPTH];

  logic [ADDRW-1:0] r_idx;
  logic [ADDRW:0]   r_n;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_alu_x;
  logic [WIDTH-1:0] r_alu_y;
  logic [OPW-1:0]   r_alu_op;
  logic [ADDRW:0]   r_correct;
  logic [ADDRW:0]   r_failed;
  logic             r_fail_valid;
  logic [ADDRW-1:0] r_first_fail;

  logic             w_busy;
  logic             w_start_ok;
  logic [ADDRW:0]   w_n_req;
  logic             w_last;
  logic             w_match;
  logic             w_settle_end;

  assign w_busy       = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign w_start_ok   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_n_req      = (bus.num_tests > DEPTH_W) ? DEPTH_W : bus.num_tests;
  assign w_last       = (({1'b0, r_idx} + ONE_N) == r_n);
  assign w_match      = (bus.alu_z == r_mem_z[r_idx]);
  assign w_settle_end = (r_cnt == ONE_C);

  // Vector storage is not reset so it survives a reset between runs.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !w_busy && ({1'b0, bus.wr_addr} < DEPTH_W)) begin
      r_mem_x[bus.wr_addr]  <= bus.wr_x;
      r_mem_y[bus.wr_addr]  <= bus.wr_y;
      r_mem_z[bus.wr_addr]  <= bus.wr_z;
      r_mem_op[bus.wr_addr] <= bus.wr_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_next = (w_n_req == '0) ? S_DONE : S_DRIVE;
        end
      end
      S_DRIVE:  w_next = S_SETTLE;
      S_SETTLE: if (w_settle_end) w_next = S_CHECK;
      S_CHECK:  w_next = w_last ? S_DONE : S_DRIVE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_n          <= '0;
      r_cnt        <= '0;
      r_alu_x      <= '0;
      r_alu_y      <= '0;
      r_alu_op     <= '0;
      r_correct    <= '0;
      r_failed     <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_n          <= w_n_req;
            r_idx        <= '0;
            r_correct    <= '0;
            r_failed     <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
          end
        end
        S_DRIVE: begin
          r_alu_x  <= r_mem_x[r_idx];
          r_alu_y  <= r_mem_y[r_idx];
          r_alu_op <= r_mem_op[r_idx];
          r_cnt    <= SETTLE_W;
        end
        S_SETTLE: begin
          if (!w_settle_end) r_cnt <= r_cnt - ONE_C;
        end
        S_CHECK: begin
          if (w_match) begin
            r_correct <= r_correct + ONE_N;
          end else begin
            r_failed <= r_failed + ONE_N;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_first_fail <= r_idx;
            end
          end
          if (!w_last) r_idx <= r_idx + ONE_I;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_x      = r_alu_x;
  assign bus.alu_y      = r_alu_y;
  assign bus.alu_op     = r_alu_op;
  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == S_DONE);
  assign bus.correct    = r_correct;
  assign bus.failed     = r_failed;
  assign bus.fail_valid = r_fail_valid;
  assign bus.first_fail = r_first_fail;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: z = x + y ALU stub, vector table loaded through the
// write port, per-run expectations queued at start and checked when done rises.
module tb_alu_vector_checker;
  localparam int W      = 16;
  localparam int OPW    = 5;
  localparam int DEPTH  = 20;
  localparam int AW     = 5;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_vector_checker_if #(.WIDTH(W), .OPW(OPW), .ADDRW(AW)) bus ();

  alu_vector_checker #(
    .WIDTH(W), .OPW(OPW), .DEPTH(DEPTH), .ADDRW(AW), .SETTLE(SETTLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.alu_z = bus.alu_x + bus.alu_y;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W-1:0]   z;
    logic [OPW-1:0] op;
  } vec_t;

  typedef struct {
    int correct;
    int failed;
    int fv;
    int ff;
    int cycles;
    int x;
    int y;
    int op;
  } exp_t;

  vec_t tbl [DEPTH];
  vec_t sh  [DEPTH];
  exp_t sbq [$];
  int   last_x = 0, last_y = 0, last_op = 0;
  int   n_cmp = 0, n_mis = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int num);
    exp_t e;
    int   n;
    e = '{default: 0};
    n = (num > DEPTH) ? DEPTH : num;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] s;
      s = sh[i].x + sh[i].y;
      if (s == sh[i].z) e.correct++;
      else begin
        if (e.failed == 0) e.ff = i;
        e.failed++;
        e.fv = 1;
      end
    end
    e.cycles = n * (SETTLE + 2) + 1;
    if (n > 0) begin
      e.x = int'(sh[n-1].x); e.y = int'(sh[n-1].y); e.op = int'(sh[n-1].op);
    end else begin
      e.x = last_x; e.y = last_y; e.op = last_op;
    end
    return e;
  endfunction

  task automatic write_vec(input int a, input vec_t v);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_x    = v.x;
    bus.wr_y    = v.y;
    bus.wr_z    = v.z;
    bus.wr_op   = v.op;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
    sh[a] = v;
  endtask

  task automatic start_run(input int num, input bit track);
    exp_t e;
    @(negedge clk);
    bus.num_tests = (AW+1)'(num);
    bus.start     = 1'b1;
    if (track) begin
      e = model(num);
      sbq.push_back(e);
      last_x = e.x; last_y = e.y; last_op = e.op;
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic finish_run(input int cyc0, input string tag);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (!bus.done && cyc < 500) begin
      @(posedge clk);
      #1 cyc++;
    end
    e = sbq.pop_front();
    cmp({tag, "_cycles"},  cyc, e.cycles);
    cmp({tag, "_done"},    int'(bus.done), 1);
    cmp({tag, "_busy"},    int'(bus.busy), 0);
    cmp({tag, "_correct"}, int'(bus.correct), e.correct);
    cmp({tag, "_failed"},  int'(bus.failed), e.failed);
    cmp({tag, "_fvalid"},  int'(bus.fail_valid), e.fv);
    cmp({tag, "_ffirst"},  int'(bus.first_fail), e.ff);
    cmp({tag, "_alu_x"},   int'(bus.alu_x), e.x);
    cmp({tag, "_alu_y"},   int'(bus.alu_y), e.y);
    cmp({tag, "_alu_op"},  int'(bus.alu_op), e.op);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_alu_x"},   int'(bus.alu_x), 0);
    cmp({tag, "_alu_y"},   int'(bus.alu_y), 0);
    cmp({tag, "_alu_op"},  int'(bus.alu_op), 0);
    cmp({tag, "_busy"},    int'(bus.busy), 0);
    cmp({tag, "_done"},    int'(bus.done), 0);
    cmp({tag, "_correct"}, int'(bus.correct), 0);
    cmp({tag, "_failed"},  int'(bus.failed), 0);
    cmp({tag, "_fvalid"},  int'(bus.fail_valid), 0);
    cmp({tag, "_ffirst"},  int'(bus.first_fail), 0);
  endtask

  initial begin
    int   cyc;
    vec_t v;

    tbl[0] = '{x: 16'd1,      y: 16'd2, z: 16'd3,  op: 5'd3};
    tbl[1] = '{x: 16'hFFFF,   y: 16'd1, z: 16'd0,  op: 5'd7};
    tbl[2] = '{x: 16'd5,      y: 16'd5, z: 16'd10, op: 5'd0};
    tbl[3] = '{x: 16'd7,      y: 16'd0, z: 16'd7,  op: 5'd12};
    for (int i = 4; i < DEPTH; i++) begin
      tbl[i].x  = 16'(i * 4099);
      tbl[i].y  = 16'(i * 517 + 3);
      tbl[i].z  = tbl[i].x + tbl[i].y + ((i == 9) ? 16'd1 : 16'd0);
      tbl[i].op = OPW'(i);
    end

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_x = '0; bus.wr_y = '0;
    bus.wr_z = '0; bus.wr_op = '0; bus.num_tests = '0; bus.start = 1'b0;
    reset = 1'b1;
    #2 check_zero("rst");
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 4; i++) write_vec(i, tbl[i]);
    start_run(4, 1'b1);
    finish_run(1, "pass4");

    v = tbl[2]; v.z = 16'd11;
    write_vec(2, v);
    start_run(4, 1'b1);
    finish_run(1, "fail2");

    start_run(0, 1'b1);
    finish_run(1, "zero");

    for (int i = 4; i < DEPTH; i++) write_vec(i, tbl[i]);
    start_run(25, 1'b1);
    finish_run(1, "clamp25");
    cmp("clamp25_sum", int'(bus.correct) + int'(bus.failed), DEPTH);

    write_vec(2, tbl[2]);
    start_run(4, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    cmp("midrst_busy", int'(bus.busy), 1);
    cmp("midrst_correct", int'(bus.correct), 1);
    reset = 1'b1;
    #1 check_zero("midrst");
    last_x = 0; last_y = 0; last_op = 0;
    @(negedge clk) reset = 1'b0;
    start_run(4, 1'b1);
    finish_run(1, "rerun");

    start_run(4, 1'b1);
    cyc = 1;
    repeat (3) begin @(posedge clk); #1 cyc++; end
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_x = 16'd1; bus.wr_y = 16'd2;
    bus.wr_z = 16'h1234; bus.wr_op = 5'd1;
    @(posedge clk);
    #1 cyc++;
    bus.wr_en = 1'b0;
    @(negedge clk);
    bus.num_tests = 6'd1; bus.start = 1'b1;
    @(posedge clk);
    #1 cyc++;
    bus.start = 1'b0;
    finish_run(cyc, "robust");
    start_run(4, 1'b1);
    finish_run(1, "robust_rerun");

    start_run(4, 1'b1);
    cyc = 1;
    while (cyc < 12) begin @(posedge clk); #1 cyc++; end
    @(negedge clk);
    bus.num_tests = 6'd4; bus.start = 1'b1;
    @(posedge clk);
    #1 cyc++;
    bus.start = 1'b0;
    finish_run(cyc, "lastchk");
    repeat (2) @(posedge clk);
    #1;
    cmp("lastchk_hold_done", int'(bus.done), 1);
    cmp("lastchk_hold_busy", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/alu_vector_checker.md
Name: alu_vector_checker

Overview:
- Hardware driver/checker for the `alu` block: the stimulus-and-compare end of the ALU interface (X, Y, ALUop in; z out), built as synthesizable RTL.
- Holds a small vector memory loaded through a write port. On `start` it plays each vector into the ALU, waits a fixed settle time, compares `alu_z` against the expected result, and keeps pass/fail counts.
- Used for on-chip self-test of the ALU and as the reusable vector engine in the team's processor benches.

Parameters:
- WIDTH, 16, data word width (matches `WORD).
- OPW, 5, ALU opcode width.
- DEPTH, 20, number of vector entries.
- ADDRW, 5, vector address width (2^ADDRW >= DEPTH).
- SETTLE, 1, cycles waited between driving a vector and sampling `alu_z` (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write one vector entry.
- wr_addr  in  ADDRW  entry index.
- wr_x  in  WIDTH  X operand.
- wr_y  in  WIDTH  Y operand.
- wr_z  in  WIDTH  expected result.
- wr_op  in  OPW  ALU opcode.
- num_tests  in  ADDRW+1  number of vectors to run; sampled on start.
- start  in  1  begin a run (single-cycle pulse).
- alu_x  out  WIDTH  to ALU X.
- alu_y  out  WIDTH  to ALU Y.
- alu_op  out  OPW  to ALU ALUop.
- alu_z  in  WIDTH  from ALU z.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start or reset.
- correct  out  ADDRW+1  matching vectors.
- failed  out  ADDRW+1  mismatching vectors.
- fail_valid  out  1  at least one mismatch this run.
- first_fail  out  ADDRW  index of first mismatch.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including alu_x, alu_y, alu_op, counts, busy, done, fail_valid and first_fail. Vector memory contents are not reset.
- Vector memory:
  - Written synchronously when wr_en=1 and busy=0.
  - wr_en is ignored while busy=1.
  - wr_addr >= DEPTH is ignored.
- States and transitions:
  - IDLE/DONE, start=1:
    - Latch n = min(num_tests, DEPTH).
    - Clear correct, failed, fail_valid, first_fail and done.
    - Set idx=0.
    - If n=0, go to DONE (done=1 next cycle, counts 0). Otherwise go to DRIVE with busy=1.
  - DRIVE (1 cycle): register mem[idx] onto alu_x/alu_y/alu_op; load settle counter = SETTLE; go to SETTLE.
  - SETTLE: decrement the counter each cycle; go to CHECK when it reaches 1.
  - CHECK (1 cycle): compare alu_z to expected[idx].
    - Equal: correct+1.
    - Not equal: failed+1. If fail_valid=0, set fail_valid=1 and first_fail=idx.
    - If idx=n-1, go to DONE. Otherwise idx+1 and go to DRIVE.
  - DONE: busy=0, done=1. alu_x/y/op hold the last vector.
- Timing:
  - Cycles per vector = SETTLE+2.
  - Full run from the start edge to done=1 = n*(SETTLE+2)+1 cycles.
- start while busy: ignored.
- start asserted in the same cycle as the final CHECK: ignored; a new start is required after done.
- start in DONE: restarts the run; the memory is unchanged.
- Invariant: correct+failed = vectors checked so far. Counters never wrap, since the maximum is DEPTH.
- Comparison is full WIDTH bitwise equality; there is no X/Z handling.

Test Plan:
- Bench ALU stub (z = x + y) with SETTLE=1:
  - Load 4 vectors: (1,2,exp 3), (0xFFFF,1,exp 0), (5,5,exp 10), (7,0,exp 7). num_tests=4, start.
  - Required: done=1 after 13 cycles; correct=4, failed=0, fail_valid=0.
- Same vectors, but entry 2 expects 11 instead of 10:
  - Required: correct=3, failed=1, fail_valid=1, first_fail=2.
  - alu_x/alu_y/alu_op equal entry 3 at done.
- num_tests=0, start:
  - Required: done=1 on the next cycle, busy never asserted, counts 0.
- num_tests=25 with DEPTH=20:
  - Required: exactly 20 vectors run; correct+failed=20.
- Assert reset mid-run, during SETTLE of vector 1:
  - Required: all outputs 0 immediately.
  - A subsequent start reruns from idx 0 on the retained memory with the same results.
- Robustness: wr_en to entry 0 with wr_z=0x1234 while busy; pulse start mid-run.
  - Required: memory unchanged (the rerun still passes); the in-flight run is unaffected and its counts are correct.
